// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment display scanner.
package seg7_pkg;

    localparam int NUM_DIGITS_DEF  = 8;
    localparam int REFRESH_DIV_DEF = 100000;
    localparam int MAX_DIGITS      = 8;

    // Anode bank fully off (active-low); narrower banks use the low bits.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
    localparam logic                  DP_OFF    = 1'b1;

    // Leading-zero blank vector: bit i set when blanking is enabled, i>0 and
    // every nibble from i up to the top digit is zero. Digit 0 always stays lit.
    function automatic logic [MAX_DIGITS-1:0] lz_blank_vec(
        input logic [4*MAX_DIGITS-1:0] nibbles,
        input logic                    lz_en,
        input int                      num_digits
    );
        logic                  upper_zero;
        logic [MAX_DIGITS-1:0] vec;
        vec        = '0;
        upper_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < num_digits) begin
                upper_zero = upper_zero && (nibbles[4*i +: 4] == 4'h0);
                vec[i]     = lz_en && (i > 0) && upper_zero;
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/seg7_display_scanner_refresh_tick_gen.sv
// Prescaler: counts 0..REFRESH_DIV-1 and flags the last cycle of each slot.
module refresh_tick_gen #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap at the end of the slot, otherwise count up.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    // Slot counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/seg7_display_scanner.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// Data is snapshotted once per frame; outputs are registered from the
// next-state index and snapshot so they change cleanly on the slot edge.
module seg7_display_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_en,
    output logic [3:0]              hex,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                    tick;

    logic [IDX_W-1:0]        idx_q,       idx_d;
    logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
    logic [NUM_DIGITS-1:0]   snap_en_q,   snap_en_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q,   snap_dp_d;
    logic                    snap_lz_q,   snap_lz_d;

    logic [3:0]              hex_q,         hex_d;
    logic [NUM_DIGITS-1:0]   anode_q,       anode_d;
    logic                    dp_q,          dp_d;
    logic                    frame_start_q, frame_start_d;

    logic [4*MAX_DIGITS-1:0] data_ext;
    logic [MAX_DIGITS-1:0]   lz_vec;
    logic                    blank;
    logic                    dp_req;

    refresh_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Digit index advance and end-of-frame snapshot capture.
    always_comb begin
        idx_d         = idx_q;
        snap_data_d   = snap_data_q;
        snap_en_d     = snap_en_q;
        snap_dp_d     = snap_dp_q;
        snap_lz_d     = snap_lz_q;
        frame_start_d = 1'b0;
        if (tick) begin
            if (idx_q == IDX_LAST) begin
                idx_d         = '0;
                snap_data_d   = data;
                snap_en_d     = digit_en;
                snap_dp_d     = dp_mask;
                snap_lz_d     = lz_en;
                frame_start_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Output decode from the upcoming index and snapshot.
    always_comb begin
        data_ext                     = '0;
        data_ext[4*NUM_DIGITS-1:0]   = snap_data_d;
        lz_vec                       = lz_blank_vec(data_ext, snap_lz_d, NUM_DIGITS);
        hex_d                        = 4'h0;
        blank                        = 1'b1;
        dp_req                       = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                hex_d  = snap_data_d[4*i +: 4];
                blank  = !snap_en_d[i] || lz_vec[i];
                dp_req = snap_dp_d[i];
            end
        end
        anode_d = ANODE_OFF[NUM_DIGITS-1:0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!blank && (idx_d == IDX_W'(i))) begin
                anode_d[i] = 1'b0;
            end
        end
        dp_d = blank ? DP_OFF : ~dp_req;
    end

    // Scan state and snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q       <= '0;
            snap_data_q <= '0;
            snap_en_q   <= '0;
            snap_dp_q   <= '0;
            snap_lz_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            snap_data_q <= snap_data_d;
            snap_en_q   <= snap_en_d;
            snap_dp_q   <= snap_dp_d;
            snap_lz_q   <= snap_lz_d;
        end
    end

    // Registered display outputs; reset forces the bank dark immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_q         <= 4'h0;
            anode_q       <= ANODE_OFF[NUM_DIGITS-1:0];
            dp_q          <= DP_OFF;
            frame_start_q <= 1'b0;
        end else begin
            hex_q         <= hex_d;
            anode_q       <= anode_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hex         = hex_q;
    assign anode       = anode_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_display_scanner.sv
// Randomized self-checking bench for seg7_display_scanner with a
// cycle-count based reference model of the scan and snapshot rules.
module tb_seg7_display_scanner;

    localparam int ND    = 8;
    localparam int RD    = 4;
    localparam int FRAME = ND * RD;

    logic          clk;
    logic          reset;
    logic [31:0]   data;
    logic [7:0]    digit_en;
    logic [7:0]    dp_mask;
    logic          lz_en;
    logic [3:0]    hex;
    logic [7:0]    anode;
    logic          dp;
    logic          frame_start;

    int            total;
    int            bad;

    // Reference model state: edges since reset release and captured frame data.
    int            e;
    logic [31:0]   m_data;
    logic [7:0]    m_en;
    logic [7:0]    m_dp;
    logic          m_lz;

    seg7_display_scanner #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .digit_en   (digit_en),
        .dp_mask    (dp_mask),
        .lz_en      (lz_en),
        .hex        (hex),
        .anode      (anode),
        .dp         (dp),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t e=%0d: got=%0h expected=%0h", tag, $time, e, got, exp);
        end
    endtask

    task automatic model_clear();
        e      = 0;
        m_data = '0;
        m_en   = '0;
        m_dp   = '0;
        m_lz   = 1'b0;
    endtask

    task automatic check_outputs();
        int          idx;
        logic [31:0] upper;
        logic        blk;
        logic [7:0]  ea;
        logic [3:0]  eh;
        logic        ed;
        logic        ef;
        idx   = (e / RD) % ND;
        upper = m_data >> (4 * idx);
        eh    = upper[3:0];
        blk   = !m_en[idx] || (m_lz && idx > 0 && upper == 32'h0);
        ea    = blk ? 8'hFF : ~(8'h01 << idx);
        ed    = blk ? 1'b1 : ~m_dp[idx];
        ef    = (e > 0) && (e % FRAME == 0);
        chk("anode", {24'h0, anode}, {24'h0, ea});
        chk("hex", {28'h0, hex}, {28'h0, eh});
        chk("dp", {31'h0, dp}, {31'h0, ed});
        chk("frame_start", {31'h0, frame_start}, {31'h0, ef});
        chk("anode_one_cold", {31'h0, ($countones(~anode) <= 1)}, 32'h1);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) begin
            e++;
            if (e % FRAME == 0) begin
                m_data = data;
                m_en   = digit_en;
                m_dp   = dp_mask;
                m_lz   = lz_en;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int guard;
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        data     = '0;
        digit_en = '0;
        dp_mask  = '0;
        lz_en    = 1'b0;
        model_clear();

        // Held in reset while inputs churn: bank stays dark.
        for (int k = 0; k < 6; k++) begin
            data     = $urandom;
            digit_en = 8'($urandom);
            dp_mask  = 8'($urandom);
            lz_en    = 1'($urandom);
            step();
        end

        // Plain scan order, then a mid-frame data change.
        data     = 32'h8765_4321;
        digit_en = 8'hFF;
        dp_mask  = 8'h00;
        lz_en    = 1'b0;
        reset    = 1'b1;
        run(FRAME + FRAME / 2);
        data = 32'hFFFF_FFFF;
        run(FRAME + FRAME / 2);

        // Leading-zero blanking, then all-zero data.
        data  = 32'h0000_0A05;
        lz_en = 1'b1;
        run(2 * FRAME);
        data = 32'h0000_0000;
        run(2 * FRAME);

        // Digit masking with a single decimal point.
        data     = 32'h1234_5678;
        lz_en    = 1'b0;
        digit_en = 8'hF0;
        dp_mask  = 8'h10;
        run(2 * FRAME);

        // Random inputs changing at random points in the frame.
        for (int k = 0; k < 12 * FRAME; k++) begin
            if ($urandom_range(7) == 0) begin
                data     = $urandom;
                digit_en = 8'($urandom);
                dp_mask  = 8'($urandom);
                lz_en    = 1'($urandom);
                if ($urandom_range(2) == 0) data = data & 32'h0000_0FFF;
            end
            step();
        end

        // Mid-frame reset at digit 5 of a lit frame.
        data     = 32'h9ABC_DEF1;
        digit_en = 8'hFF;
        dp_mask  = 8'hA5;
        lz_en    = 1'b0;
        run(FRAME);
        guard = 0;
        while (((e / RD) % ND) != 5 && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        chk("reach_idx5", {31'h0, (guard < 2 * FRAME)}, 32'h1);
        reset = 1'b0;
        #1;
        chk("async_reset_anode", {24'h0, anode}, 32'hFF);
        model_clear();
        check_outputs();
        run(3);
        reset = 1'b1;
        for (int k = 0; k < 3 * FRAME; k++) begin
            if ($urandom_range(15) == 0) begin
                data     = $urandom;
                digit_en = 8'($urandom);
                dp_mask  = 8'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
